// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, the bubble/halt instruction words and the
// opcode values that decode (and benches) use to build instruction words.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;

  localparam logic [5:0]  OPC_J   = 6'b000010;
  localparam logic [5:0]  OPC_BEQ = 6'b000100;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// next_pc_sel: combinational next-PC arithmetic for the fetch stage.
// Produces the sequential successor of the fetch PC and the redirect target
// of the instruction sitting in ID (jump wins over branch when both are set).
module next_pc_sel (
  input  logic [31:0] pc_i,
  input  logic [31:0] if_id_pc4_i,
  input  logic [31:0] id_imm_sext_i,
  input  logic [25:0] id_jump_idx_i,
  input  logic        id_jump_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] redirect_target_o
);

  // Sequential successor and branch/jump target; all sums wrap modulo 2^32.
  always_comb begin
    pc_plus4_o = pc_i + 32'd4;
    if (id_jump_i) begin
      redirect_target_o = {if_id_pc4_i[31:28], id_jump_idx_i, 2'b00};
    end else begin
      redirect_target_o = if_id_pc4_i + (id_imm_sext_i << 2);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives instruction memory and loads the IF/ID
// pipeline register. Redirects from ID are applied here with a one-bubble
// penalty. Define FETCH_PERF_EN to add fetch and bubble performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        id_branch,
  input  logic        id_zero,
  input  logic        id_jump,
  input  logic [31:0] id_imm_sext,
  input  logic [25:0] id_jump_idx,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  if_id_instr_q;
  logic [31:0]  if_id_pc4_q;
  logic         if_id_valid_q;
  logic         halted_q;

  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;
  logic         taken;

`ifdef FETCH_PERF_EN
  logic [31:0]  perf_fetch_cnt_q;
  logic [31:0]  perf_bubble_cnt_q;
`endif

  next_pc_sel u_next_pc_sel (
    .pc_i              (pc_q),
    .if_id_pc4_i       (if_id_pc4_q),
    .id_imm_sext_i     (id_imm_sext),
    .id_jump_idx_i     (id_jump_idx),
    .id_jump_i         (id_jump),
    .pc_plus4_o        (pc_plus4),
    .redirect_target_o (redirect_target)
  );

  // Redirect only counts for a real instruction in ID, never for a bubble.
  always_comb begin
    taken = ((id_branch & id_zero) | id_jump) & if_id_valid_q;
  end

  // Fetch FSM: PC update and IF/ID load in priority stall > redirect > halt > fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= 32'h0;
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
`ifdef FETCH_PERF_EN
      perf_fetch_cnt_q  <= 32'h0;
      perf_bubble_cnt_q <= 32'h0;
`endif
    end else begin
      case (state_q)
        BOOT: begin
          if_id_instr_q <= NOP_INSTR;
          if_id_pc4_q   <= 32'h0;
          if_id_valid_q <= 1'b0;
          state_q       <= RUN;
`ifdef FETCH_PERF_EN
          if (!stall) perf_bubble_cnt_q <= perf_bubble_cnt_q + 32'd1;
`endif
        end
        RUN: begin
          if (stall) begin
            state_q <= RUN;
          end else if (taken) begin
            pc_q          <= redirect_target;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
`ifdef FETCH_PERF_EN
            perf_bubble_cnt_q <= perf_bubble_cnt_q + 32'd1;
`endif
          end else if (imem_rdata == HALT_INSTR) begin
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b1;
            state_q       <= HALTED;
`ifdef FETCH_PERF_EN
            perf_bubble_cnt_q <= perf_bubble_cnt_q + 32'd1;
`endif
          end else begin
            pc_q          <= pc_plus4;
            if_id_instr_q <= imem_rdata;
            if_id_pc4_q   <= pc_plus4;
            if_id_valid_q <= 1'b1;
`ifdef FETCH_PERF_EN
            perf_fetch_cnt_q <= perf_fetch_cnt_q + 32'd1;
`endif
          end
        end
        HALTED: begin
          if (!stall) begin
            if_id_instr_q <= NOP_INSTR;
            if_id_pc4_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
`ifdef FETCH_PERF_EN
            perf_bubble_cnt_q <= perf_bubble_cnt_q + 32'd1;
`endif
          end
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;
`ifdef FETCH_PERF_EN
  assign perf_fetch_cnt  = perf_fetch_cnt_q;
  assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. The bench plays both the
// instruction memory (drives imem_rdata for the current PC) and the decode
// stage (drives the id_* redirect signals), with hand-computed expectations.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        id_branch;
  logic        id_zero;
  logic        id_jump;
  logic [31:0] id_imm_sext;
  logic [25:0] id_jump_idx;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int vectors;
  int miscompares;

  logic [31:0] beqWord;
  logic [31:0] jWord;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .id_branch   (id_branch),
    .id_zero     (id_zero),
    .id_jump     (id_jump),
    .id_imm_sext (id_imm_sext),
    .id_jump_idx (id_jump_idx),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it, away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare the full visible fetch-stage state against expectations.
  task automatic checkState(input string tag, input logic [31:0] expPc, input logic [31:0] expInstr,
                            input logic [31:0] expPc4, input logic expValid, input logic expHalted);
    checkOutput({tag, ".pc"}, pc, expPc);
    checkOutput({tag, ".imem_addr"}, imem_addr, expPc);
    checkOutput({tag, ".instr"}, if_id_instr, expInstr);
    checkOutput({tag, ".pc4"}, if_id_pc4, expPc4);
    checkOutput({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, expValid});
    checkOutput({tag, ".halted"}, {31'h0, halted}, {31'h0, expHalted});
  endtask

  // Directed sequence: reset, boot, branch, gating, jump, stall, halt, wrap.
  initial begin
    vectors     = 0;
    miscompares = 0;
    beqWord     = {OPC_BEQ, 26'h000_FFFE};
    jWord       = {OPC_J, 26'h000_0040};
    rst         = 1'b1;
    stall       = 1'b0;
    id_branch   = 1'b0;
    id_zero     = 1'b0;
    id_jump     = 1'b0;
    id_imm_sext = 32'h0;
    id_jump_idx = 26'h0;
    imem_rdata  = 32'h2002_0005;

    applyStimulus();
    applyStimulus();
    checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    rst = 1'b0;
    applyStimulus();
    checkState("boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus();
    checkState("fetch0", 32'h4, 32'h2002_0005, 32'h4, 1'b1, 1'b0);

    imem_rdata = 32'h0000_0001;
    applyStimulus();
    imem_rdata = 32'h0000_0002;
    applyStimulus();
    imem_rdata = beqWord;
    applyStimulus();
    checkState("fetchBeq", 32'h10, beqWord, 32'h10, 1'b1, 1'b0);

    id_branch   = 1'b1;
    id_zero     = 1'b1;
    id_imm_sext = 32'hFFFF_FFFE;
    imem_rdata  = 32'hFFFF_FFFF;
    applyStimulus();
    checkState("beqTaken", 32'h8, 32'h0, 32'h0, 1'b0, 1'b0);

    imem_rdata = jWord;
    applyStimulus();
    checkState("bubbleGate", 32'hC, jWord, 32'hC, 1'b1, 1'b0);

    id_imm_sext = 32'h03FF_FFFD;
    imem_rdata  = 32'h0000_0003;
    applyStimulus();
    checkState("farBranch", 32'h1000_0000, 32'h0, 32'h0, 1'b0, 1'b0);

    id_branch  = 1'b0;
    id_zero    = 1'b0;
    imem_rdata = jWord;
    applyStimulus();
    checkState("fetchJ", 32'h1000_0004, jWord, 32'h1000_0004, 1'b1, 1'b0);

    id_jump     = 1'b1;
    id_jump_idx = 26'h000_0040;
    id_branch   = 1'b1;
    id_zero     = 1'b1;
    id_imm_sext = 32'h0000_0001;
    imem_rdata  = 32'h0000_0004;
    applyStimulus();
    checkState("jumpPrio", 32'h1000_0100, 32'h0, 32'h0, 1'b0, 1'b0);

    id_jump    = 1'b0;
    id_branch  = 1'b0;
    id_zero    = 1'b0;
    imem_rdata = beqWord;
    applyStimulus();
    checkState("fetchBeq2", 32'h1000_0104, beqWord, 32'h1000_0104, 1'b1, 1'b0);

    stall       = 1'b1;
    id_branch   = 1'b1;
    id_zero     = 1'b1;
    id_imm_sext = 32'h0000_0010;
    imem_rdata  = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkState("stallHold", 32'h1000_0104, beqWord, 32'h1000_0104, 1'b1, 1'b0);
    end
    stall = 1'b0;
    applyStimulus();
    checkState("stallRelease", 32'h1000_0144, 32'h0, 32'h0, 1'b0, 1'b0);

    id_branch  = 1'b0;
    id_zero    = 1'b0;
    imem_rdata = 32'h3333_3333;
    applyStimulus();
    checkState("fetchSeq", 32'h1000_0148, 32'h3333_3333, 32'h1000_0148, 1'b1, 1'b0);

    id_branch   = 1'b1;
    id_zero     = 1'b1;
    id_imm_sext = 32'hFBFF_FFB6;
    imem_rdata  = 32'h0000_0005;
    applyStimulus();
    checkState("branchTo20", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);

    id_branch  = 1'b0;
    id_zero    = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    applyStimulus();
    checkState("halt", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
    imem_rdata = 32'h0000_0006;
    applyStimulus();
    checkState("haltedHold", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);
    stall = 1'b1;
    applyStimulus();
    checkState("haltedStall", 32'h20, 32'h0, 32'h0, 1'b0, 1'b1);

    rst = 1'b1;
    applyStimulus();
    checkState("resetMidStall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    rst        = 1'b0;
    stall      = 1'b0;
    imem_rdata = 32'h1111_1111;
    applyStimulus();
    checkState("boot2", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus();
    checkState("fetch0b", 32'h4, 32'h1111_1111, 32'h4, 1'b1, 1'b0);

    id_branch   = 1'b1;
    id_zero     = 1'b1;
    id_imm_sext = 32'hFFFF_FFFE;
    imem_rdata  = 32'h5555_5555;
    applyStimulus();
    checkState("branchToTop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0);

    id_branch  = 1'b0;
    id_zero    = 1'b0;
    imem_rdata = 32'h4444_4444;
    applyStimulus();
    checkState("pcWrap", 32'h0, 32'h4444_4444, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
